// File: rtl/io_sevenseg_ctrl.sv
// Memory-mapped seven-segment display controller.
// Registers: DATA (RW), CTRL (RW: enable, decimal, leading-zero blank, blink), STATUS (RO).
// Decimal mode runs a sequential double-dabble converter, one shift per clock.
module io_sevenseg_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 8'h10,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   io_addr,
  input  logic [31:0]             io_data_in,
  input  logic                    io_write,
  input  logic                    io_read,
  output logic [31:0]             io_data_out,
  output logic                    busy,
  output logic [NUM_DIGITS*7-1:0] seg_n
);

  localparam int unsigned DispW = 4 * NUM_DIGITS;
  localparam int unsigned CntW  = $clog2(BLINK_DIV);

  localparam logic [ADDR_WIDTH-1:0] AddrData   = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] AddrCtrl   = BASE_ADDR + ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus = BASE_ADDR + ADDR_WIDTH'(2);

  localparam logic [6:0] GlyphBlank = 7'b1111111;
  localparam logic [6:0] GlyphDash  = 7'b0111111;
  localparam logic [6:0] GlyphZero  = 7'b1000000;

  typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

  // CTRL bit positions
  localparam int unsigned CtrlEn    = 0;
  localparam int unsigned CtrlDec   = 1;
  localparam int unsigned CtrlLzb   = 2;
  localparam int unsigned CtrlBlink = 3;

  logic             sel_data, sel_ctrl, sel_status;
  logic             wr_data, wr_ctrl;
  logic [31:0]      rd_val;

  logic [31:0]      data_q;
  logic [3:0]       ctrl_q;

  state_e           state_q;
  logic [31:0]      bin_q;
  logic [39:0]      bcd_q;
  logic [39:0]      bcd_adj;
  logic [5:0]       shift_cnt_q;
  logic             busy_q;
  logic             overflow_q;
  logic [DispW-1:0] disp_q;
  logic             hex_ovf;
  logic             bcd_ovf;

  logic [CntW-1:0]  blink_cnt_q;
  logic             blink_on_q;

  logic [NUM_DIGITS*7-1:0] seg_d;
  logic             lead;
  logic [3:0]       nib;
  logic [6:0]       glyph;

  assign sel_data   = (io_addr == AddrData);
  assign sel_ctrl   = (io_addr == AddrCtrl);
  assign sel_status = (io_addr == AddrStatus);
  assign wr_data    = io_write & sel_data;
  assign wr_ctrl    = io_write & sel_ctrl;
  assign busy       = busy_q;

  // Hex overflow: any DATA bit above the displayed nibbles.
  if (DispW < 32) begin : g_hex_ovf
    assign hex_ovf = |data_q[31:DispW];
  end else begin : g_no_hex_ovf
    assign hex_ovf = 1'b0;
  end

  assign bcd_ovf = |bcd_q[39:DispW];

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0:    hex_glyph = 7'b1000000;
      4'h1:    hex_glyph = 7'b1111001;
      4'h2:    hex_glyph = 7'b0100100;
      4'h3:    hex_glyph = 7'b0110000;
      4'h4:    hex_glyph = 7'b0011001;
      4'h5:    hex_glyph = 7'b0010010;
      4'h6:    hex_glyph = 7'b0000010;
      4'h7:    hex_glyph = 7'b1111000;
      4'h8:    hex_glyph = 7'b0000000;
      4'h9:    hex_glyph = 7'b0010000;
      4'hA:    hex_glyph = 7'b0001000;
      4'hB:    hex_glyph = 7'b0000011;
      4'hC:    hex_glyph = 7'b1000110;
      4'hD:    hex_glyph = 7'b0100001;
      4'hE:    hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // Register file writes
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= 4'h1;
    end else begin
      if (wr_data) data_q <= io_data_in;
      if (wr_ctrl) ctrl_q <= io_data_in[3:0];
    end
  end

  // Read mux; unmapped offsets read as zero
  always_comb begin
    rd_val = '0;
    if (sel_data)        rd_val = data_q;
    else if (sel_ctrl)   rd_val = {28'b0, ctrl_q};
    else if (sel_status) rd_val = {30'b0, overflow_q, busy_q};
  end

  // Registered read data; holds when no read strobe
  always_ff @(posedge clk) begin
    if (rst)          io_data_out <= '0;
    else if (io_read) io_data_out <= rd_val;
  end

  // Double-dabble add-3 step applied to every BCD nibble before the shift
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 10; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  // Conversion FSM and display register; writes take priority so the last write wins
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      disp_q      <= '0;
    end else if (wr_data && ctrl_q[CtrlDec]) begin
      state_q     <= StConvert;
      bin_q       <= io_data_in;
      bcd_q       <= '0;
      shift_cnt_q <= 6'd32;
      busy_q      <= 1'b1;
    end else if (wr_ctrl && io_data_in[CtrlDec]) begin
      state_q     <= StConvert;
      bin_q       <= data_q;
      bcd_q       <= '0;
      shift_cnt_q <= 6'd32;
      busy_q      <= 1'b1;
    end else if (wr_ctrl) begin
      // Leaving decimal mode abandons any conversion in flight
      state_q <= StIdle;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Hex mode tracks DATA continuously
          if (!ctrl_q[CtrlDec]) begin
            disp_q     <= data_q[DispW-1:0];
            overflow_q <= hex_ovf;
          end
        end
        StConvert: begin
          {bcd_q, bin_q} <= {bcd_adj[38:0], bin_q, 1'b0};
          shift_cnt_q    <= shift_cnt_q - 6'd1;
          if (shift_cnt_q == 6'd1) state_q <= StCommit;
        end
        StCommit: begin
          disp_q     <= bcd_q[DispW-1:0];
          overflow_q <= bcd_ovf;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Blink divider; held cleared with phase on while blink is disabled
  always_ff @(posedge clk) begin
    if (rst || !ctrl_q[CtrlBlink]) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == CntW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CntW'(1);
    end
  end

  // Glyph selection; walks from the top digit so 'lead' tracks all-zero prefixes
  always_comb begin
    seg_d = '1;
    lead  = 1'b1;
    nib   = '0;
    glyph = GlyphBlank;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = disp_q[4*k +: 4];
      if (nib != 4'h0) lead = 1'b0;
      if (!ctrl_q[CtrlEn] || !blink_on_q)         glyph = GlyphBlank;
      else if (overflow_q)                          glyph = GlyphDash;
      else if (ctrl_q[CtrlLzb] && lead && (k != 0)) glyph = GlyphBlank;
      else                                          glyph = hex_glyph(nib);
      seg_d[7*k +: 7] = glyph;
    end
  end

  // Registered segment outputs
  always_ff @(posedge clk) begin
    if (rst) seg_n <= {NUM_DIGITS{GlyphZero}};
    else     seg_n <= seg_d;
  end

endmodule

// File: tb/tb_io_sevenseg_ctrl.sv
// Directed bench for io_sevenseg_ctrl: 6 digits, BLINK_DIV=4, base word address 0x10.
module tb_io_sevenseg_ctrl;

  localparam logic [7:0] AData   = 8'h10;
  localparam logic [7:0] ACtrl   = 8'h11;
  localparam logic [7:0] AStatus = 8'h12;

  localparam logic [41:0] SegZeros  = {6{7'h40}};
  localparam logic [41:0] SegDashes = {6{7'h3F}};
  localparam logic [41:0] SegBlank  = {6{7'h7F}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  io_addr = '0;
  logic [31:0] io_data_in = '0;
  logic        io_write = 1'b0;
  logic        io_read = 1'b0;
  logic [31:0] io_data_out;
  logic        busy;
  logic [41:0] seg_n;

  int vectors = 0;
  int miscompares = 0;

  io_sevenseg_ctrl #(
    .NUM_DIGITS(6),
    .ADDR_WIDTH(8),
    .BASE_ADDR (8'h10),
    .BLINK_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io_addr    (io_addr),
    .io_data_in (io_data_in),
    .io_write   (io_write),
    .io_read    (io_read),
    .io_data_out(io_data_out),
    .busy       (busy),
    .seg_n      (seg_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_data_in = d; io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_read = 1'b1;
    @(negedge clk);
    io_read = 1'b0;
    d = io_data_out;
  endtask

  // Returns the number of sampled cycles busy was high, then one more cycle for seg_n.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (seg_n !== SegZeros) begin
      miscompares++; $display("FAIL reset_seg: got %h want %h", seg_n, SegZeros);
    end
    vectors++;
    if (io_data_out !== 32'h0) begin
      miscompares++; $display("FAIL reset_rdata: got %h want 0", io_data_out);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    bus_read(ACtrl, r);
    vectors++;
    if (r !== 32'h1) begin
      miscompares++; $display("FAIL reset_ctrl: got %h want 1", r);
    end
    bus_read(AStatus, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++; $display("FAIL reset_status: got %h want 0", r);
    end
  endtask

  task automatic test_hex();
    logic [31:0] r;
    logic [41:0] exp_seg;
    exp_seg = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    bus_write(AData, 32'h00AB_CDEF);
    repeat (2) @(negedge clk);
    vectors++;
    if (seg_n !== exp_seg) begin
      miscompares++; $display("FAIL hex_seg: got %h want %h", seg_n, exp_seg);
    end
    bus_read(AData, r);
    vectors++;
    if (r !== 32'h00AB_CDEF) begin
      miscompares++; $display("FAIL hex_read_data: got %h want 00abcdef", r);
    end
    bus_read(AStatus, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++; $display("FAIL hex_status: got %h want 0", r);
    end
    // Same-cycle read and write of DATA returns the old value
    @(negedge clk);
    io_addr = AData; io_data_in = 32'h55; io_write = 1'b1; io_read = 1'b1;
    @(negedge clk);
    io_write = 1'b0; io_read = 1'b0;
    vectors++;
    if (io_data_out !== 32'h00AB_CDEF) begin
      miscompares++; $display("FAIL rw_same_cycle: got %h want 00abcdef", io_data_out);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (io_data_out !== 32'h00AB_CDEF) begin
      miscompares++; $display("FAIL rdata_hold: got %h want 00abcdef", io_data_out);
    end
    bus_read(AData, r);
    vectors++;
    if (r !== 32'h55) begin
      miscompares++; $display("FAIL rw_new_value: got %h want 55", r);
    end
    bus_write(AData, 32'h0100_0000);
    repeat (2) @(negedge clk);
    vectors++;
    if (seg_n !== SegDashes) begin
      miscompares++; $display("FAIL hex_ovf_seg: got %h want %h", seg_n, SegDashes);
    end
    bus_read(AStatus, r);
    vectors++;
    if (r !== 32'h2) begin
      miscompares++; $display("FAIL hex_ovf_status: got %h want 2", r);
    end
  endtask

  task automatic test_decimal();
    logic [31:0] r;
    logic [41:0] exp_seg;
    int n;
    bus_write(ACtrl, 32'h7);
    bus_write(AData, 32'd123456);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL dec_busy_start: got %b want 1", busy);
    end
    wait_idle(n);
    vectors++;
    if (n !== 33) begin
      miscompares++; $display("FAIL dec_busy_len: got %0d want 33", n);
    end
    exp_seg = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    vectors++;
    if (seg_n !== exp_seg) begin
      miscompares++; $display("FAIL dec_123456: got %h want %h", seg_n, exp_seg);
    end
    bus_read(AStatus, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++; $display("FAIL dec_status: got %h want 0", r);
    end
    bus_write(AData, 32'd42);
    wait_idle(n);
    exp_seg = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24};
    vectors++;
    if (n !== 33 || seg_n !== exp_seg) begin
      miscompares++; $display("FAIL dec_42: got %h n=%0d want %h n=33", seg_n, n, exp_seg);
    end
    bus_write(AData, 32'd1002);
    wait_idle(n);
    exp_seg = {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h24};
    vectors++;
    if (seg_n !== exp_seg) begin
      miscompares++; $display("FAIL dec_1002: got %h want %h", seg_n, exp_seg);
    end
    bus_write(AData, 32'd0);
    wait_idle(n);
    exp_seg = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    vectors++;
    if (seg_n !== exp_seg) begin
      miscompares++; $display("FAIL dec_zero: got %h want %h", seg_n, exp_seg);
    end
  endtask

  task automatic test_overflow_restart();
    logic [31:0] r;
    logic [41:0] exp_seg;
    int n;
    bus_write(AData, 32'd1000000);
    wait_idle(n);
    vectors++;
    if (seg_n !== SegDashes) begin
      miscompares++; $display("FAIL dec_ovf_seg: got %h want %h", seg_n, SegDashes);
    end
    bus_read(AStatus, r);
    vectors++;
    if (r !== 32'h2) begin
      miscompares++; $display("FAIL dec_ovf_status: got %h want 2", r);
    end
    bus_write(AData, 32'd999999999);
    repeat (9) @(negedge clk);
    bus_write(AData, 32'd7);
    wait_idle(n);
    vectors++;
    if (n !== 33) begin
      miscompares++; $display("FAIL restart_busy_len: got %0d want 33", n);
    end
    exp_seg = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
    vectors++;
    if (seg_n !== exp_seg) begin
      miscompares++; $display("FAIL restart_seg: got %h want %h", seg_n, exp_seg);
    end
    bus_read(AStatus, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++; $display("FAIL restart_status: got %h want 0", r);
    end
  endtask

  task automatic test_blink();
    logic [41:0] val;
    logic [41:0] exp_seg;
    val = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78};
    bus_write(ACtrl, 32'h9);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_seg = ((k >= 5 && k <= 8) || (k >= 13 && k <= 16)) ? SegBlank : val;
      vectors++;
      if (seg_n !== exp_seg) begin
        miscompares++; $display("FAIL blink_k%0d: got %h want %h", k, seg_n, exp_seg);
      end
    end
    bus_write(ACtrl, 32'h1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (seg_n !== val) begin
        miscompares++; $display("FAIL blink_off_k%0d: got %h want %h", k, seg_n, val);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_convert();
    logic [31:0] r;
    int n;
    bus_write(ACtrl, 32'h3);
    wait_idle(n);
    bus_write(AData, 32'd123456);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || seg_n !== SegZeros) begin
      miscompares++; $display("FAIL rst_mid: busy=%b seg=%h want busy=0 seg=%h", busy, seg_n, SegZeros);
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || seg_n !== SegZeros) begin
      miscompares++; $display("FAIL rst_discard: busy=%b seg=%h want busy=0 seg=%h", busy, seg_n, SegZeros);
    end
    bus_read(AData, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++; $display("FAIL rst_data: got %h want 0", r);
    end
    bus_read(ACtrl, r);
    vectors++;
    if (r !== 32'h1) begin
      miscompares++; $display("FAIL rst_ctrl: got %h want 1", r);
    end
  endtask

  task automatic test_out_of_window();
    logic [31:0] r;
    logic [41:0] exp_seg;
    exp_seg = {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30};
    bus_write(AData, 32'h123);
    bus_write(8'h13, 32'hFFFF_FFFF);
    bus_write(AStatus, 32'hFFFF_FFFF);
    bus_write(8'h0F, 32'hFFFF_FFFF);
    bus_write(8'h20, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    vectors++;
    if (seg_n !== exp_seg) begin
      miscompares++; $display("FAIL oow_seg: got %h want %h", seg_n, exp_seg);
    end
    bus_read(AData, r);
    vectors++;
    if (r !== 32'h123) begin
      miscompares++; $display("FAIL oow_data: got %h want 123", r);
    end
    bus_read(AStatus, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++; $display("FAIL oow_status: got %h want 0", r);
    end
    bus_read(ACtrl, r);
    vectors++;
    if (r !== 32'h1) begin
      miscompares++; $display("FAIL oow_ctrl: got %h want 1", r);
    end
    bus_read(8'h13, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++; $display("FAIL oow_read3: got %h want 0", r);
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_overflow_restart();
    test_blink();
    test_reset_mid_convert();
    test_out_of_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
